// File: rtl/clock_pkg.sv
// Shared types and constants for the multi-alarm clock: field widths,
// time-field limits, the ring FSM state enum and an hh:mm range check.
package clock_pkg;

    localparam int HW = 5;
    localparam int MW = 6;

    localparam logic [HW-1:0] HOUR_MAX = 5'd23;
    localparam logic [MW-1:0] MIN_MAX  = 6'd59;
    localparam logic [MW-1:0] SEC_MAX  = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RING    = 2'd1,
        ST_SNOOZED = 2'd2
    } state_t;

    function automatic logic hm_valid(input logic [HW-1:0] h, input logic [MW-1:0] m);
        return (h <= HOUR_MAX) && (m <= MIN_MAX);
    endfunction

endpackage

// File: rtl/hms_counter.sv
// Prescaler plus 24-hour hh:mm:ss counter with a validated load port.
// Exposes the advance strobe and the post-advance time so the owner can match alarms.
module hms_counter
    import clock_pkg::*;
#(
    parameter int CLK_PER_SEC = 50_000_000
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load_en,
    input  logic [HW-1:0] i_load_h,
    input  logic [MW-1:0] i_load_m,
    output logic [HW-1:0] o_hh,
    output logic [MW-1:0] o_mm,
    output logic [MW-1:0] o_ss,
    output logic          o_tick,
    output logic          o_adv,
    output logic [HW-1:0] o_nxt_h,
    output logic [MW-1:0] o_nxt_m,
    output logic [MW-1:0] o_nxt_s
);

    localparam int            PW       = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] r_pre;
    logic [HW-1:0] r_hh;
    logic [MW-1:0] r_mm;
    logic [MW-1:0] r_ss;
    logic          r_tick;

    logic w_load;
    logic w_term;
    logic w_carry_m;
    logic w_carry_h;

    assign w_load    = i_load_en && hm_valid(i_load_h, i_load_m);
    assign w_term    = (r_pre == PRE_LAST);
    assign w_carry_m = (r_ss == SEC_MAX);
    assign w_carry_h = w_carry_m && (r_mm == MIN_MAX);

    // A valid load owns the cycle: the advance that would have happened is dropped.
    assign o_adv = w_term && !w_load;

    assign o_nxt_s = w_carry_m ? '0 : r_ss + 1'b1;
    assign o_nxt_m = !w_carry_m ? r_mm : ((r_mm == MIN_MAX) ? '0 : r_mm + 1'b1);
    assign o_nxt_h = !w_carry_h ? r_hh : ((r_hh == HOUR_MAX) ? '0 : r_hh + 1'b1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre  <= '0;
            r_hh   <= '0;
            r_mm   <= '0;
            r_ss   <= '0;
            r_tick <= 1'b0;
        end else if (w_load) begin
            r_pre  <= '0;
            r_hh   <= i_load_h;
            r_mm   <= i_load_m;
            r_ss   <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_term;
            if (w_term) begin
                r_pre <= '0;
                r_hh  <= o_nxt_h;
                r_mm  <= o_nxt_m;
                r_ss  <= o_nxt_s;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign o_hh   = r_hh;
    assign o_mm   = r_mm;
    assign o_ss   = r_ss;
    assign o_tick = r_tick;

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour clock with NUM_ALARMS programmable slots and one ring FSM.
// Optional snooze support is compiled in with `define MULTI_ALARM_SNOOZE_EN.
module multi_alarm_clock
    import clock_pkg::*;
#(
    parameter  int CLK_PER_SEC = 50_000_000,
    parameter  int NUM_ALARMS  = 4,
    parameter  int RING_SECS   = 10,
    parameter  int SNOOZE_MIN  = 5,
    localparam int AW          = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [4:0]            set_h,
    input  logic [5:0]            set_m,
    input  logic                  alarm_wr,
    input  logic [AW-1:0]         alarm_idx,
    input  logic [4:0]            alarm_h,
    input  logic [5:0]            alarm_m,
    input  logic                  alarm_on,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [4:0]            hh,
    output logic [5:0]            mm,
    output logic [5:0]            ss,
    output logic                  tick,
    output logic                  ringing,
    output logic [AW-1:0]         ring_idx,
    output logic [NUM_ALARMS-1:0] alarm_mask
);

    localparam int RCW = $clog2(RING_SECS + 1);

    logic          w_adv;
    logic [HW-1:0] w_nxt_h;
    logic [MW-1:0] w_nxt_m;
    logic [MW-1:0] w_nxt_s;

    hms_counter #(
        .CLK_PER_SEC (CLK_PER_SEC)
    ) u_hms (
        .clk       (clk),
        .rst       (rst),
        .i_load_en (set_en),
        .i_load_h  (set_h),
        .i_load_m  (set_m),
        .o_hh      (hh),
        .o_mm      (mm),
        .o_ss      (ss),
        .o_tick    (tick),
        .o_adv     (w_adv),
        .o_nxt_h   (w_nxt_h),
        .o_nxt_m   (w_nxt_m),
        .o_nxt_s   (w_nxt_s)
    );

    // ---------------- alarm slots ----------------
    logic [HW-1:0]         r_alarm_h [NUM_ALARMS];
    logic [MW-1:0]         r_alarm_m [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] r_alarm_on;
    logic                  w_wr_ok;

    assign w_wr_ok = alarm_wr && (int'(alarm_idx) < NUM_ALARMS) && hm_valid(alarm_h, alarm_m);

    // NOTE: the slot array is reset explicitly because a cleared slot must read
    // as disabled 00:00; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_alarm_h[i] <= '0;
                r_alarm_m[i] <= '0;
            end
            r_alarm_on <= '0;
        end else if (w_wr_ok) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (alarm_idx == AW'(i)) begin
                    r_alarm_h[i]  <= alarm_h;
                    r_alarm_m[i]  <= alarm_m;
                    r_alarm_on[i] <= alarm_on;
                end
            end
        end
    end

    assign alarm_mask = r_alarm_on;

    // ---------------- match, lowest index wins ----------------
    logic          w_hit;
    logic [AW-1:0] w_hit_idx;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        if (w_adv && (w_nxt_s == '0)) begin
            for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
                if (r_alarm_on[i] && (r_alarm_h[i] == w_nxt_h) && (r_alarm_m[i] == w_nxt_m)) begin
                    w_hit     = 1'b1;
                    w_hit_idx = AW'(i);
                end
            end
        end
    end

    // ---------------- ring FSM ----------------
    state_t        r_state;
    state_t        w_state_nxt;
    logic [RCW-1:0] r_ring_cnt;
    logic [RCW-1:0] w_ring_cnt_nxt;
    logic [AW-1:0] r_ring_idx;
    logic [AW-1:0] w_ring_idx_nxt;
    logic          r_ringing;

`ifdef MULTI_ALARM_SNOOZE_EN
    localparam int SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int SCW       = $clog2(SNZ_TICKS + 1);

    logic [SCW-1:0] r_snz_cnt;
    logic [SCW-1:0] w_snz_cnt_nxt;
`else
    logic w_unused_snooze;
    assign w_unused_snooze = snooze;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_ring_cnt_nxt = r_ring_cnt;
        w_ring_idx_nxt = r_ring_idx;
`ifdef MULTI_ALARM_SNOOZE_EN
        w_snz_cnt_nxt  = r_snz_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_state_nxt    = ST_RING;
                    w_ring_idx_nxt = w_hit_idx;
                    w_ring_cnt_nxt = RCW'(RING_SECS);
                end
            end
            ST_RING: begin
                if (dismiss) begin
                    w_state_nxt = ST_IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
                end else if (snooze) begin
                    w_state_nxt   = ST_SNOOZED;
                    w_snz_cnt_nxt = SCW'(SNZ_TICKS);
`endif
                end else if (w_adv) begin
                    // The advance that takes the count to zero ends the ring.
                    if (r_ring_cnt <= RCW'(1)) begin
                        w_state_nxt    = ST_IDLE;
                        w_ring_cnt_nxt = '0;
                    end else begin
                        w_ring_cnt_nxt = r_ring_cnt - 1'b1;
                    end
                end
            end
`ifdef MULTI_ALARM_SNOOZE_EN
            ST_SNOOZED: begin
                if (dismiss) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_adv) begin
                    if (r_snz_cnt <= SCW'(1)) begin
                        w_state_nxt    = ST_RING;
                        w_snz_cnt_nxt  = '0;
                        w_ring_cnt_nxt = RCW'(RING_SECS);
                    end else begin
                        w_snz_cnt_nxt = r_snz_cnt - 1'b1;
                    end
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ring_cnt <= '0;
            r_ring_idx <= '0;
            r_ringing  <= 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
            r_snz_cnt  <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ring_cnt <= w_ring_cnt_nxt;
            r_ring_idx <= w_ring_idx_nxt;
            r_ringing  <= (w_state_nxt == ST_RING);
`ifdef MULTI_ALARM_SNOOZE_EN
            r_snz_cnt  <= w_snz_cnt_nxt;
`endif
        end
    end

    assign ringing  = r_ringing;
    assign ring_idx = r_ring_idx;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Self-checking bench for multi_alarm_clock: directed scenarios plus random
// stimulus, all compared every cycle against a seconds-of-day reference model.
module tb_multi_alarm_clock;

    localparam int CPS = 4;
    localparam int NA  = 4;
    localparam int RS  = 10;
    localparam int SM  = 5;
    localparam int AW  = 2;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          set_en = 1'b0;
    logic [4:0]    set_h = '0;
    logic [5:0]    set_m = '0;
    logic          alarm_wr = 1'b0;
    logic [AW-1:0] alarm_idx = '0;
    logic [4:0]    alarm_h = '0;
    logic [5:0]    alarm_m = '0;
    logic          alarm_on = 1'b0;
    logic          snooze = 1'b0;
    logic          dismiss = 1'b0;
    logic [4:0]    hh;
    logic [5:0]    mm;
    logic [5:0]    ss;
    logic          tick;
    logic          ringing;
    logic [AW-1:0] ring_idx;
    logic [NA-1:0] alarm_mask;

    always #5 clk = ~clk;

    multi_alarm_clock #(
        .CLK_PER_SEC (CPS),
        .NUM_ALARMS  (NA),
        .RING_SECS   (RS),
        .SNOOZE_MIN  (SM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .set_en     (set_en),
        .set_h      (set_h),
        .set_m      (set_m),
        .alarm_wr   (alarm_wr),
        .alarm_idx  (alarm_idx),
        .alarm_h    (alarm_h),
        .alarm_m    (alarm_m),
        .alarm_on   (alarm_on),
        .snooze     (snooze),
        .dismiss    (dismiss),
        .hh         (hh),
        .mm         (mm),
        .ss         (ss),
        .tick       (tick),
        .ringing    (ringing),
        .ring_idx   (ring_idx),
        .alarm_mask (alarm_mask)
    );

    int n_total = 0;
    int n_pass  = 0;
    int tick_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: time is seconds-of-day, ring/snooze windows are
    // expressed as absolute counts of elapsed seconds.
    int tod, phase, sec_n, mode, exp_idx, ring_end, resume_at;
    bit exp_tick;
    int a_h [NA];
    int a_m [NA];
    bit a_on [NA];

    task automatic model_edge();
        bit load_ok, adv, hit;
        int hit_i;
        if (rst) begin
            tod = 0; phase = 0; sec_n = 0; mode = M_IDLE; exp_idx = 0; exp_tick = 0;
            ring_end = 0; resume_at = 0;
            for (int i = 0; i < NA; i++) begin a_h[i] = 0; a_m[i] = 0; a_on[i] = 0; end
            return;
        end
        load_ok  = set_en && (set_h <= 23) && (set_m <= 59);
        adv      = (phase == CPS - 1) && !load_ok;
        exp_tick = adv;
        if (load_ok) begin
            tod = int'(set_h) * 3600 + int'(set_m) * 60;
            phase = 0;
        end else if (phase == CPS - 1) begin
            phase = 0;
            tod = (tod + 1) % 86400;
            sec_n++;
        end else begin
            phase++;
        end
        hit = 0; hit_i = 0;
        if (adv && (tod % 60 == 0)) begin
            for (int i = 0; i < NA; i++)
                if (!hit && a_on[i] && (a_h[i] * 3600 + a_m[i] * 60 == tod)) begin
                    hit = 1; hit_i = i;
                end
        end
        if (alarm_wr && (alarm_h <= 23) && (alarm_m <= 59)) begin
            a_h[alarm_idx]  = int'(alarm_h);
            a_m[alarm_idx]  = int'(alarm_m);
            a_on[alarm_idx] = alarm_on;
        end
        case (mode)
            M_IDLE: if (hit) begin mode = M_RING; exp_idx = hit_i; ring_end = sec_n + RS; end
            M_RING: begin
                if (dismiss) mode = M_IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
                else if (snooze) begin mode = M_SNZ; resume_at = sec_n + SM * 60; end
`endif
                else if (adv && sec_n >= ring_end) mode = M_IDLE;
            end
            default: begin
                if (dismiss) mode = M_IDLE;
                else if (adv && sec_n >= resume_at) begin mode = M_RING; ring_end = sec_n + RS; end
            end
        endcase
    endtask

    task automatic compare_all();
        int mask;
        mask = 0;
        for (int i = 0; i < NA; i++) if (a_on[i]) mask |= (1 << i);
        if (tick === 1'b1) tick_seen++;
        check("hh", 32'(hh), tod / 3600);
        check("mm", 32'(mm), (tod / 60) % 60);
        check("ss", 32'(ss), tod % 60);
        check("tick", 32'(tick), 32'(exp_tick));
        check("ringing", 32'(ringing), (mode == M_RING) ? 1 : 0);
        check("ring_idx", 32'(ring_idx), exp_idx);
        check("alarm_mask", 32'(alarm_mask), mask);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        rst = 0; set_en = 0; alarm_wr = 0; snooze = 0; dismiss = 0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_time(input int h, input int m);
        set_en = 1; set_h = 5'(h); set_m = 6'(m);
        cycle();
    endtask

    task automatic wr_alarm(input int i, input int h, input int m, input bit on);
        alarm_wr = 1; alarm_idx = AW'(i); alarm_h = 5'(h); alarm_m = 6'(m); alarm_on = on;
        cycle();
    endtask

    initial begin
        int r, j, th, tm;

        // Reset state
        rst = 1; cycle(); rst = 1; cycle();
        check("rst_time", {15'd0, hh, mm, ss}, 0);
        check("rst_ringing", 32'(ringing), 0);
        check("rst_mask", 32'(alarm_mask), 0);

        // Rollover 23:59:00 -> 00:00:00 in 60 s, one tick per CPS clocks
        set_time(23, 59);
        tick_seen = 0;
        run(60 * CPS);
        check("roll_time", {15'd0, hh, mm, ss}, 0);
        check("roll_ticks", tick_seen, 60);

        // Input validation
        set_time(12, 34);
        set_time(24, 10);
        check("bad_set_h", 32'(hh), 12);
        check("bad_set_m", 32'(mm), 34);
        wr_alarm(1, 5, 60, 1);
        check("bad_alarm_mask", 32'(alarm_mask), 0);

        // Basic alarm and timeout
        wr_alarm(2, 7, 30, 1);
        set_time(7, 29);
        run(59 * CPS);
        check("pre_alarm_ring", 32'(ringing), 0);
        run(CPS);
        check("alarm_ring", 32'(ringing), 1);
        check("alarm_idx", 32'(ring_idx), 2);
        check("alarm_mm", 32'(mm), 30);
        run((RS - 1) * CPS);
        check("ring_last_sec", 32'(ringing), 1);
        run(CPS);
        check("ring_timeout", 32'(ringing), 0);
        wr_alarm(2, 7, 30, 0);

        // Priority: lowest index wins
        wr_alarm(0, 6, 0, 1);
        wr_alarm(3, 6, 0, 1);
        set_time(5, 59);
        run(60 * CPS);
        check("prio_idx0", 32'(ring_idx), 0);
        check("prio_ring0", 32'(ringing), 1);
        dismiss = 1; cycle();
        check("dismiss", 32'(ringing), 0);
        wr_alarm(0, 6, 0, 0);
        set_time(5, 59);
        run(60 * CPS);
        check("prio_idx3", 32'(ring_idx), 3);
        check("prio_ring3", 32'(ringing), 1);
        dismiss = 1; cycle();
        wr_alarm(3, 6, 0, 0);

        // Snooze at 07:30:03, off-advance cycle
        wr_alarm(2, 7, 30, 1);
        set_time(7, 29);
        run(63 * CPS);
        run(1);
        snooze = 1; cycle();
`ifdef MULTI_ALARM_SNOOZE_EN
        check("snooze_drop", 32'(ringing), 0);
`else
        check("snooze_ignored", 32'(ringing), 1);
`endif
        run(1197);
        check("snooze_wait", 32'(ringing), 0);
        run(1);
        check("snooze_time", {15'd0, hh, mm, ss}, {15'd0, 5'd7, 6'd35, 6'd3});
`ifdef MULTI_ALARM_SNOOZE_EN
        check("snooze_rering", 32'(ringing), 1);
`else
        check("snooze_rering", 32'(ringing), 0);
`endif
        dismiss = 1; cycle();
        run(20 * CPS);
        check("post_dismiss", 32'(ringing), 0);
        wr_alarm(2, 7, 30, 0);

        // Reset mid-ring
        wr_alarm(1, 8, 0, 1);
        set_time(7, 59);
        run(61 * CPS);
        check("pre_rst_ring", 32'(ringing), 1);
        rst = 1; cycle();
        check("rst_mid_ring", 32'(ringing), 0);
        check("rst_mid_mask", 32'(alarm_mask), 0);
        check("rst_mid_time", {15'd0, hh, mm, ss}, 0);

        // Randomized stimulus, checked every cycle by the model
        for (int k = 0; k < 12000; k++) begin
            r = int'($urandom_range(0, 999));
            if (r < 5) begin
                j  = int'($urandom_range(0, NA - 1));
                th = a_h[j];
                tm = (a_m[j] == 0) ? 0 : a_m[j] - 1;
                if ($urandom_range(0, 9) == 0) th = 24;
                set_en = 1; set_h = 5'(th); set_m = 6'(tm);
            end
            if ($urandom_range(0, 199) == 0) begin
                alarm_wr  = 1;
                alarm_idx = AW'($urandom_range(0, NA - 1));
                alarm_h   = 5'(tod / 3600);
                alarm_m   = ($urandom_range(0, 7) == 0) ? 6'd60 : 6'(((tod / 60) + 1) % 60);
                alarm_on  = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 249) == 0) snooze = 1;
            if ($urandom_range(0, 499) == 0) dismiss = 1;
            if ($urandom_range(0, 2999) == 0) rst = 1;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised 24-hour time-of-day clock with NUM_ALARMS independently programmable alarm slots, configurable ring duration and optional snooze. It derives a 1 Hz tick from the system clock through an internal prescaler. It keeps hh:mm:ss and arbitrates alarm matches through a single ring state machine. It sits under the display/UI logic, which owns mode selection and formatting (12 h conversion included).

## Interface
- CLK_PER_SEC, default 50_000_000: clk cycles per second; legal range ≥1.
- NUM_ALARMS, default 4: alarm slots; legal range 1..16.
- RING_SECS, default 10: seconds an alarm rings before auto-stop; legal range ≥1.
- SNOOZE_MIN, default 5: snooze delay in minutes; legal range 1..59.
- AW (localparam): max(1, $clog2(NUM_ALARMS)).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- set_en  in  1  load time, one-cycle strobe.
- set_h  in  5  hour to load (0..23).
- set_m  in  6  minute to load (0..59).
- alarm_wr  in  1  write alarm slot, one-cycle strobe.
- alarm_idx  in  AW  slot to write.
- alarm_h  in  5  alarm hour.
- alarm_m  in  6  alarm minute.
- alarm_on  in  1  enable bit written with the slot.
- snooze  in  1  snooze request, one-cycle strobe.
- dismiss  in  1  stop ringing / cancel snooze.
- hh  out  5  hours, 0..23.
- mm  out  6  minutes.
- ss  out  6  seconds.
- tick  out  1  one-cycle pulse on the edge where ss advances.
- ringing  out  1  alarm active.
- ring_idx  out  AW  slot that triggered the current ring or snooze.
- alarm_mask  out  NUM_ALARMS  enable bit of each slot.

## Operation
- Reset: all outputs are 0, the prescaler is 0, every slot is h=0, m=0, disabled, and the FSM is IDLE. Reset mid-ring or mid-snooze returns to IDLE immediately.
- Prescaler counts 0..CLK_PER_SEC-1. At terminal count it wraps to 0 and advances time.
- Time advance:
  - ss 59→0 carries to mm.
  - mm 59→0 carries to hh.
  - hh 23→0.
- set_en with set_h≤23 and set_m≤59 loads hh/mm, clears ss and the prescaler, and suppresses that cycle's advance. Out-of-range values are ignored entirely.
- alarm_wr with alarm_idx<NUM_ALARMS, alarm_h≤23 and alarm_m≤59 writes the slot. Otherwise it is ignored. A write never disturbs an in-progress ring.
- Match: evaluated only on an advance edge whose next time is hh:mm:00 and equals an enabled slot. A set_en load never triggers a match. When several slots match, the lowest index wins; the others are dropped.
- FSM states: IDLE, RING, SNOOZED.
  - IDLE→RING on match. Latch ring_idx and load ring_cnt=RING_SECS.
  - RING: ring_cnt decrements on each tick. Leave to IDLE when ring_cnt reaches 0 or on dismiss. Go to SNOOZED on snooze, loading snz_cnt=SNOOZE_MIN*60.
  - SNOOZED: snz_cnt decrements on each tick. At 0, go to RING with ring_cnt reloaded. dismiss goes to IDLE.
  - Matches arriving while in RING or SNOOZED are ignored.
  - dismiss and snooze in the same cycle: dismiss wins.
- ringing = (state==RING).
- Counter widths: $clog2(RING_SECS+1) and $clog2(SNOOZE_MIN*60+1). There is no overflow path.

## Timing
- All outputs are registered.
- tick is high in the cycle immediately after the advance edge, coincident with the new ss value.
- ringing rises in the same cycle hh:mm:00 first appears on the outputs, and stays high for exactly RING_SECS ticks unless stopped.
- A snooze strobe at edge N drops ringing at N+1. ringing rises again on the tick where the counted-down snooze period completes, i.e. SNOOZE_MIN*60 ticks later.
- set_en / alarm_wr take effect on the next edge. The new value is visible one cycle after the strobe.

## Configuration
- MULTI_ALARM_SNOOZE_EN defined: snooze behaves as above.
- Not defined:
  - The SNOOZED state and snz_cnt are removed.
  - The snooze input is ignored.
  - RING exits only by dismiss or timeout.

## Structure
- Shared package clock_pkg holds:
  - the state enum (IDLE/RING/SNOOZED);
  - the constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23;
  - the widths 5/6 for hour and minute/second fields.
- One sub-module, hms_counter: prescaler plus hh:mm:ss with a load port and a tick output. The alarm slots and FSM stay in the top level.

## Test plan
All scenarios use CLK_PER_SEC=4, NUM_ALARMS=4, RING_SECS=10, SNOOZE_MIN=5.
- Rollover: reset, set 23:59, run 60 ticks → 00:00:00; tick pulses once every 4 clocks.
- Input validation: set_h=24 → time unchanged. alarm_wr with alarm_m=60 → slot unchanged.
- Basic alarm and timeout: slot 2 = 07:30 on, set 07:29, run 60 ticks → ringing=1 and ring_idx=2 at 07:30:00; ringing=0 after 10 ticks.
- Priority: slots 0 and 3 both 06:00 on → ring_idx=0. With slot 0 disabled, the same setup gives ring_idx=3.
- Snooze: snooze at 07:30:03 → ringing=0, re-asserts at 07:35:03. dismiss then → IDLE, no further ring.
- Reset mid-ring: rst while ringing → ringing=0, alarm_mask=0, time 00:00:00. Build without MULTI_ALARM_SNOOZE_EN: snooze has no effect.
